// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared constants for the UART receive path: framing byte, error codes,
// command-parser state encoding and the baud divider.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT = 5208;

  localparam logic [7:0] SOF_BYTE_DEF = 8'h55;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } parser_state_t;

endpackage

// File: rtl/uart_byte_timeout.sv
`timescale 1ns/1ps
// Inter-byte watchdog: counts enabled cycles since the last clear and
// pulses expire_o for one cycle when TERMINAL cycles have elapsed.
module uart_byte_timeout #(
  parameter int unsigned TERMINAL = 104160
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TERMINAL + 1);
  localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear in the expiry cycle suppresses the expiry.
  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  // Next count: restart on clear, disable or expiry, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || expire_o) cnt_d = '0;
    else                            cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
`timescale 1ns/1ps
// Frame parser: SOF, ADDR, LEN, payload, CHECKSUM. Payload is buffered and
// only emitted as auto-incrementing (addr, data) writes once the checksum
// has been verified.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 104160,
  parameter logic [7:0]  SOF_BYTE    = SOF_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_addr,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       rx_drop,
  output logic       busy
);

  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  parser_state_t state_q, state_d;
  logic [7:0] base_q, base_d, len_q, len_d, idx_q, idx_d, k_q, k_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] out_addr_q, out_addr_d, out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic       frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic       rx_drop_q, rx_drop_d;
  logic [1:0] err_code_q, err_code_d;
  logic       buf_we, tmo_en, tmo_expire;
  logic [7:0] buf_q [0:MAX_LEN-1];

  assign tmo_en = (state_q == S_ADDR) || (state_q == S_LEN) ||
                  (state_q == S_PAYLOAD) || (state_q == S_CSUM);

  uart_byte_timeout #(.TERMINAL(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (rx_done),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  // Next-state and output logic for the frame FSM.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    k_d         = k_q;
    csum_d      = csum_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_drop_d   = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
    case (state_q)
      S_IDLE: if (rx_done && rx_data == SOF_BYTE) state_d = S_ADDR;
      S_ADDR: if (rx_done) begin
        base_d  = rx_data;
        csum_d  = rx_data;
        state_d = S_LEN;
      end
      S_LEN: if (rx_done) begin
        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_LEN;
          state_d     = S_IDLE;
        end else begin
          len_d   = rx_data;
          csum_d  = csum_q + rx_data;
          idx_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (rx_done) begin
        buf_we = 1'b1;
        csum_d = csum_q + rx_data;
        idx_d  = idx_q + 8'd1;
        if (idx_q + 8'd1 == len_q) state_d = S_CSUM;
      end
      S_CSUM: if (rx_done) begin
        if (rx_data == csum_q) begin
          frame_ok_d  = 1'b1;
          out_valid_d = 1'b1;
          out_addr_d  = base_q;
          out_data_d  = buf_q[0];
          out_last_d  = (len_q == 8'd1);
          k_d         = 8'd1;
          state_d     = S_DRAIN;
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_CSUM;
          state_d     = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (rx_done) rx_drop_d = 1'b1;
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            // k_q already indexes the next command's payload byte.
            out_addr_d = out_addr_q + 8'd1;
            out_data_d = buf_q[k_q[AW-1:0]];
            out_last_d = (k_q == len_q - 8'd1);
            k_d        = k_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Expiry is only raised in frame states with no byte this cycle.
    if (tmo_expire) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = S_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      csum_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_drop_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      csum_q      <= csum_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      rx_drop_q   <= rx_drop_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= rx_data;
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign rx_drop   = rx_drop_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 40;

  logic       clk = 1'b0, rst = 1'b1, rx_done = 1'b0, out_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       out_valid, out_last, frame_ok, frame_err, rx_drop, busy;
  logic [7:0] out_addr, out_data;
  logic [1:0] err_code;

  int errors = 0;
  int checks = 0;

  uart_cmd_parser #(.MAX_LEN(8), .TIMEOUT_CYC(TMO), .SOF_BYTE(8'h55)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code), .rx_drop(rx_drop), .busy(busy)
  );

  always #10 clk = ~clk;

  // One-cycle strobe; returns on the negedge after the sampling posedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_done = 1'b1; rx_data = b;
    @(negedge clk); rx_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_addr, out_data, out_last, frame_ok, frame_err, err_code, rx_drop, busy} !== 23'd0) begin
      errors++; $display("FAIL reset_outputs: got v=%b a=%h d=%h l=%b ok=%b err=%b code=%0d drop=%b busy=%b expected all 0",
        out_valid, out_addr, out_data, out_last, frame_ok, frame_err, err_code, rx_drop, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    out_ready = 1'b1;
    send_byte(8'h55);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b expected 1", busy); end
    send_byte(8'h10); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h8A);
    checks++;
    if ({frame_ok, out_valid, out_addr, out_data, out_last} !== {1'b1, 1'b1, 8'h10, 8'hAB, 1'b0}) begin
      errors++; $display("FAIL good_cmd0: got ok=%b v=%b a=%h d=%h l=%b expected ok=1 v=1 a=10 d=ab l=0",
        frame_ok, out_valid, out_addr, out_data, out_last);
    end
    @(negedge clk);
    checks++;
    if ({frame_ok, out_valid, out_addr, out_data, out_last} !== {1'b0, 1'b1, 8'h11, 8'hCD, 1'b1}) begin
      errors++; $display("FAIL good_cmd1: got ok=%b v=%b a=%h d=%h l=%b expected ok=0 v=1 a=11 d=cd l=1",
        frame_ok, out_valid, out_addr, out_data, out_last);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL good_done: got v=%b busy=%b expected v=0 busy=0", out_valid, busy);
    end
  endtask

  task automatic test_bad_csum();
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h8B);
    checks++;
    if ({frame_err, err_code, out_valid, busy} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL csum_err: got err=%b code=%0d v=%b busy=%b expected err=1 code=2 v=0 busy=0",
        frame_err, err_code, out_valid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, frame_err} !== 2'b00) begin
        errors++; $display("FAIL csum_quiet[%0d]: got v=%b err=%b expected 0 0", i, out_valid, frame_err);
      end
    end
    // Recovery: the good frame again.
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h8A);
    checks++;
    if ({frame_ok, out_valid, out_addr, out_data} !== {1'b1, 1'b1, 8'h10, 8'hAB}) begin
      errors++; $display("FAIL csum_recover: got ok=%b v=%b a=%h d=%h expected 1 1 10 ab",
        frame_ok, out_valid, out_addr, out_data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_len_err();
    send_byte(8'h55); send_byte(8'h20); send_byte(8'h00);
    checks++;
    if ({frame_err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
      errors++; $display("FAIL len_zero: got err=%b code=%0d busy=%b expected 1 1 0", frame_err, err_code, busy);
    end
    send_byte(8'h55); send_byte(8'h20);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL len_pulse_width: got %b expected 0", frame_err); end
    send_byte(8'h09);
    checks++;
    if ({frame_err, err_code, busy, out_valid} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL len_nine: got err=%b code=%0d busy=%b v=%b expected 1 1 0 0",
        frame_err, err_code, busy, out_valid);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'h55); send_byte(8'h30); send_byte(8'h03); send_byte(8'h11);
    repeat (TMO - 1) @(negedge clk);
    checks++;
    if ({frame_err, busy} !== 2'b01) begin
      errors++; $display("FAIL tmo_early: got err=%b busy=%b expected err=0 busy=1", frame_err, busy);
    end
    @(negedge clk);
    checks++;
    if ({frame_err, err_code, busy, out_valid} !== {1'b1, 2'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tmo_fire: got err=%b code=%0d busy=%b v=%b expected 1 3 0 0",
        frame_err, err_code, busy, out_valid);
    end
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b expected 0", frame_err); end
  endtask

  task automatic test_stall_wrap();
    out_ready = 1'b0;
    send_byte(8'h55); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
    checks++;
    if ({frame_ok, out_valid, out_addr, out_data, out_last} !== {1'b1, 1'b1, 8'hFF, 8'h01, 1'b0}) begin
      errors++; $display("FAIL stall_first: got ok=%b v=%b a=%h d=%h l=%b expected 1 1 ff 01 0",
        frame_ok, out_valid, out_addr, out_data, out_last);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_addr, out_data, out_last} !== {1'b1, 8'hFF, 8'h01, 1'b0}) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b a=%h d=%h l=%b expected 1 ff 01 0",
          i, out_valid, out_addr, out_data, out_last);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_addr, out_data, out_last} !== {1'b1, 8'h00, 8'h02, 1'b1}) begin
      errors++; $display("FAIL stall_wrap: got v=%b a=%h d=%h l=%b expected 1 00 02 1",
        out_valid, out_addr, out_data, out_last);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL stall_done: got v=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_drain_drop();
    out_ready = 1'b0;
    send_byte(8'h55); send_byte(8'h40); send_byte(8'h01); send_byte(8'h77); send_byte(8'hB8);
    checks++;
    if ({frame_ok, out_valid, out_addr, out_data, out_last} !== {1'b1, 1'b1, 8'h40, 8'h77, 1'b1}) begin
      errors++; $display("FAIL drop_frame: got ok=%b v=%b a=%h d=%h l=%b expected 1 1 40 77 1",
        frame_ok, out_valid, out_addr, out_data, out_last);
    end
    send_byte(8'h55);
    checks++;
    if ({rx_drop, busy, out_valid, out_addr, out_data} !== {1'b1, 1'b1, 1'b1, 8'h40, 8'h77}) begin
      errors++; $display("FAIL drop_sof: got drop=%b busy=%b v=%b a=%h d=%h expected 1 1 1 40 77",
        rx_drop, busy, out_valid, out_addr, out_data);
    end
    send_byte(8'h0F);
    checks++; if (rx_drop !== 1'b1) begin errors++; $display("FAIL drop_0f: got %b expected 1", rx_drop); end
    @(negedge clk);
    checks++; if (rx_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_width: got %b expected 0", rx_drop); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL drop_done: got v=%b busy=%b expected 0 0", out_valid, busy);
    end
    send_byte(8'h55); send_byte(8'h50); send_byte(8'h01); send_byte(8'h09); send_byte(8'h5A);
    checks++;
    if ({frame_ok, out_valid, out_addr, out_data, out_last} !== {1'b1, 1'b1, 8'h50, 8'h09, 1'b1}) begin
      errors++; $display("FAIL drop_next_frame: got ok=%b v=%b a=%h d=%h l=%b expected 1 1 50 09 1",
        frame_ok, out_valid, out_addr, out_data, out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    send_byte(8'h55); send_byte(8'h60);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, frame_err, frame_ok, out_valid} !== 4'b0000) begin
      errors++; $display("FAIL midreset: got busy=%b err=%b ok=%b v=%b expected 0 0 0 0",
        busy, frame_err, frame_ok, out_valid);
    end
    rst = 1'b0;
    send_byte(8'h12);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignore: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_err();
    test_timeout();
    test_stall_wrap();
    test_drain_drop();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
